// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: instruction encoding constants, word size and the
// default reset PC used by the fetch front end.
package cpu_defs_pkg;

    localparam int          INST_W           = 32;
    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // True when a byte address is not on a word boundary
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next fetch-address selector for the fetch front end.
// Priority: redirect (word-aligned target) > stall (hold) > sequential +4.
// Also reports whether the redirect target carried non-zero byte-offset bits.
module pc_next_mux
    import cpu_defs_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_fetch_pc,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_target,
    output logic [ADDR_W-1:0] o_next_pc,
    output logic              o_align_err
);

    // Select the next fetch PC and flag a misaligned redirect target
    always_comb begin
        o_next_pc   = i_fetch_pc;
        o_align_err = 1'b0;
        if (i_redirect) begin
            o_next_pc   = {i_redirect_target[ADDR_W-1:2], 2'b00};
            o_align_err = is_misaligned(i_redirect_target[1:0]);
        end else if (i_stall) begin
            o_next_pc   = i_fetch_pc;
        end else begin
            o_next_pc   = i_fetch_pc + ADDR_W'(WORD_BYTES);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: two-stage pipe (fetch address -> in-flight ->
// output) feeding the datapath PC input. A synchronous-read instruction memory
// returns data one enabled cycle after the address is issued.
// Optional build macro FETCH_COUNT_EN adds the fetch_count port and counter.
module pc_fetch_unit
    import cpu_defs_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [DATA_W-1:0] inst_out,
    output logic              inst_valid,
    output logic              addr_err
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]       fetch_count
`endif
);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_pc_out;
    logic [DATA_W-1:0] r_inst_out;
    logic              r_inst_valid;
    logic              r_addr_err;

    logic [ADDR_W-1:0] w_next_pc;
    logic              w_align_err;
    logic              w_advance;

    assign w_advance = ~redirect & ~stall;

    pc_next_mux #(
        .ADDR_W (ADDR_W)
    ) u_next_mux (
        .i_fetch_pc        (r_fetch_pc),
        .i_stall           (stall),
        .i_redirect        (redirect),
        .i_redirect_target (redirect_target),
        .o_next_pc         (w_next_pc),
        .o_align_err       (w_align_err)
    );

    // Pipeline state: redirect squashes in-flight work, stall holds, else advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= {ADDR_W{1'b0}};
            r_inflight    <= 1'b0;
            r_pc_out      <= {ADDR_W{1'b0}};
            r_inst_out    <= DATA_W'(NOP);
            r_inst_valid  <= 1'b0;
            r_addr_err    <= 1'b0;
        end else begin
            r_fetch_pc <= w_next_pc;
            r_addr_err <= r_addr_err | w_align_err;
            if (redirect) begin
                // Output PC/data hold their stale values; only valid is dropped
                r_inflight   <= 1'b0;
                r_inst_valid <= 1'b0;
            end else if (stall) begin
                r_inflight   <= r_inflight;
                r_inst_valid <= r_inst_valid;
            end else begin
                r_pc_out      <= r_inflight_pc;
                r_inst_out    <= imem_rdata;
                r_inst_valid  <= r_inflight;
                r_inflight_pc <= r_fetch_pc;
                r_inflight    <= 1'b1;
            end
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] r_fetch_count;

    // Count advances that deliver a valid instruction to the output stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_count <= 32'd0;
        end else if (w_advance && r_inflight) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end else begin
            r_fetch_count <= r_fetch_count;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

    // Memory is read whenever the pipe moves; a stall freezes its read data
    assign imem_en    = ~stall | redirect;
    assign imem_addr  = r_fetch_pc;
    assign pc_out     = r_pc_out;
    assign pc_plus4   = r_pc_out + ADDR_W'(WORD_BYTES);
    assign inst_out   = r_inst_out;
    assign inst_valid = r_inst_valid;
    assign addr_err   = r_addr_err;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. Instance A uses RESET_PC=0, instance B
// uses RESET_PC=FFFFFFF8 to exercise address wrap. Memory word at address a
// holds A0000000 + (a >> 2).
`timescale 1ns/1ps
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;

    logic        imem_en_a, inst_valid_a, addr_err_a;
    logic [31:0] imem_addr_a, imem_rdata_a, pc_out_a, pc_plus4_a, inst_out_a;
    logic        imem_en_b, inst_valid_b, addr_err_b;
    logic [31:0] imem_addr_b, imem_rdata_b, pc_out_b, pc_plus4_b, inst_out_b;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_a, fetch_count_b;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) u_dut_a (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_en(imem_en_a),
        .imem_addr(imem_addr_a), .imem_rdata(imem_rdata_a), .pc_out(pc_out_a),
        .pc_plus4(pc_plus4_a), .inst_out(inst_out_a), .inst_valid(inst_valid_a),
        .addr_err(addr_err_a)
`ifdef FETCH_COUNT_EN
        , .fetch_count(fetch_count_a)
`endif
    );

    pc_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFF8)) u_dut_b (
        .clk(clk), .reset(reset), .stall(1'b0), .redirect(1'b0),
        .redirect_target(32'h0000_0000), .imem_en(imem_en_b),
        .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b), .pc_out(pc_out_b),
        .pc_plus4(pc_plus4_b), .inst_out(inst_out_b), .inst_valid(inst_valid_b),
        .addr_err(addr_err_b)
`ifdef FETCH_COUNT_EN
        , .fetch_count(fetch_count_b)
`endif
    );

    // Synchronous-read instruction memories
    always @(posedge clk) begin
        if (imem_en_a) imem_rdata_a <= 32'hA000_0000 + (imem_addr_a >> 2);
        if (imem_en_b) imem_rdata_b <= 32'hA000_0000 + (imem_addr_b >> 2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_valid;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        tick(); tick();
        // Reset state
        chk("rst_valid", {31'd0, inst_valid_a}, 32'd0);
        chk("rst_pc_out", pc_out_a, 32'h0);
        chk("rst_inst", inst_out_a, 32'h0);
        chk("rst_err", {31'd0, addr_err_a}, 32'd0);
        chk("rst_addr_a", imem_addr_a, 32'h0);
        chk("rst_addr_b", imem_addr_b, 32'hFFFF_FFF8);
        chk("rst_en", {31'd0, imem_en_a}, 32'd1);
`ifdef FETCH_COUNT_EN
        chk("rst_cnt", fetch_count_a, 32'd0);
`endif
        reset = 1'b0;
        chk("t1_addr0", imem_addr_a, 32'h0);

        // Sequential fetch and first-valid latency; wrap on instance B
        tick();
        chk("t1_addr1", imem_addr_a, 32'h4);
        chk("t1_bubble", {31'd0, inst_valid_a}, 32'd0);
        tick();
        chk("t1_valid", {31'd0, inst_valid_a}, 32'd1);
        chk("t1_pc0", pc_out_a, 32'h0);
        chk("t1_inst0", inst_out_a, 32'hA000_0000);
        chk("t1_plus4", pc_plus4_a, 32'h4);
        chk("t1_addr2", imem_addr_a, 32'h8);
        chk("t5_pc0", pc_out_b, 32'hFFFF_FFF8);
        chk("t5_valid", {31'd0, inst_valid_b}, 32'd1);
        chk("t5_inst0", inst_out_b, 32'hDFFF_FFFE);
        tick();
        chk("t1_pc1", pc_out_a, 32'h4);
        chk("t1_inst1", inst_out_a, 32'hA000_0001);
        chk("t5_pc1", pc_out_b, 32'hFFFF_FFFC);
        chk("t5_plus4", pc_plus4_b, 32'h0);
        tick();
        chk("t1_pc2", pc_out_a, 32'h8);
        chk("t5_pc2", pc_out_b, 32'h0);
        chk("t5_inst2", inst_out_b, 32'hA000_0000);
        chk("t5_err", {31'd0, addr_err_b}, 32'd0);

        // Stall for three cycles while pc_out=8
        stall = 1'b1;
        #1;
        chk("t2_en", {31'd0, imem_en_a}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_pc", pc_out_a, 32'h8);
            chk("t2_hold_inst", inst_out_a, 32'hA000_0002);
            chk("t2_hold_addr", imem_addr_a, 32'h10);
        end
        stall = 1'b0;
        tick();
        chk("t2_pc3", pc_out_a, 32'hC);
        chk("t2_inst3", inst_out_a, 32'hA000_0003);
        tick();
        chk("t2_pc4", pc_out_a, 32'h10);

        // Redirect to 0x40, asserted together with stall
        stall = 1'b1; redirect = 1'b1; redirect_target = 32'h40;
        #1;
        chk("t3_en", {31'd0, imem_en_a}, 32'd1);
        tick();
        stall = 1'b0; redirect = 1'b0;
        chk("t3_bub1", {31'd0, inst_valid_a}, 32'd0);
        chk("t3_addr", imem_addr_a, 32'h40);
        tick();
        chk("t3_bub2", {31'd0, inst_valid_a}, 32'd0);
        tick();
        chk("t3_valid", {31'd0, inst_valid_a}, 32'd1);
        chk("t3_pc40", pc_out_a, 32'h40);
        chk("t3_inst40", inst_out_a, 32'hA000_0010);
        tick();
        chk("t3_pc44", pc_out_a, 32'h44);
        chk("t3_noerr", {31'd0, addr_err_a}, 32'd0);

        // Misaligned redirect target 0x42
        redirect = 1'b1; redirect_target = 32'h42;
        tick();
        redirect = 1'b0;
        chk("t4_err", {31'd0, addr_err_a}, 32'd1);
        chk("t4_addr", imem_addr_a, 32'h40);
        tick(); tick();
        chk("t4_pc40", pc_out_a, 32'h40);
        chk("t4_valid", {31'd0, inst_valid_a}, 32'd1);
        tick();
        chk("t4_pc44", pc_out_a, 32'h44);
        chk("t4_sticky", {31'd0, addr_err_a}, 32'd1);

        // Asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        chk("t6_valid", {31'd0, inst_valid_a}, 32'd0);
        chk("t6_pc", pc_out_a, 32'h0);
        chk("t6_addr_a", imem_addr_a, 32'h0);
        chk("t6_err", {31'd0, addr_err_a}, 32'd0);
        chk("t6_addr_b", imem_addr_b, 32'hFFFF_FFF8);
        chk("t6_pc_b", pc_out_b, 32'h0);
        tick();
        reset = 1'b0;

`ifdef FETCH_COUNT_EN
        // Ten edges with a redirect on the fourth
        n_valid = 0;
        for (int i = 0; i < 10; i++) begin
            redirect = (i == 3);
            redirect_target = 32'h80;
            tick();
            if (inst_valid_a) n_valid++;
        end
        redirect = 1'b0;
        chk("t7_nvalid", n_valid, 32'd7);
        chk("t7_count", fetch_count_a, n_valid);
        chk("t7_pc", pc_out_a, 32'h90);
`else
        n_valid = 0;
        tick(); tick();
        if (inst_valid_a) n_valid++;
        chk("t6_restart_pc", pc_out_a, 32'h0);
        chk("t6_restart_v", n_valid, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
